// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//
// Purpose:
//   Writer side of the core's instruction memory. Receives a framed program
//   image over a valid/ready byte stream, assembles little-endian 32-bit
//   words, writes them to consecutive instruction-memory word addresses and
//   holds the core in reset until the whole image has been written and its
//   checksum verified.
//
//   Frame on the wire (every multi-byte field is LSB first):
//     4 bytes  magic word (MAGIC)
//     4 bytes  N, number of payload words
//     4*N      payload bytes
//     1 byte   checksum = XOR of all payload bytes
//
// Parameters:
//   ADDR_WIDTH  instruction-memory word-address width (capacity 2**ADDR_WIDTH)
//   MAGIC       expected frame header value
//
// Ports:
//   clk           in   clock
//   rst           in   synchronous active-low reset
//   in_valid      in   byte source has data
//   in_ready      out  loader accepts a byte this cycle
//   in_data       in   byte value [7:0]
//   reload        in   single-cycle pulse, restarts loading from DONE or ERR
//   imem_wr_en    out  instruction-memory write strobe (one cycle per word)
//   imem_wr_addr  out  word address of the write [ADDR_WIDTH-1:0]
//   imem_wr_data  out  write data [31:0]
//   core_rst_n    out  registered active-low reset to the core pipeline
//   done          out  image loaded and verified
//   error         out  frame error (sticky until reload or rst)
// ---------------------------------------------------------------------------
module prog_loader #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] MAGIC      = 32'h4C564931
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_data,
    input  logic                  reload,
    output logic                  imem_wr_en,
    output logic [ADDR_WIDTH-1:0] imem_wr_addr,
    output logic [31:0]           imem_wr_data,
    output logic                  core_rst_n,
    output logic                  done,
    output logic                  error
);

    // Word counter and stored length are one bit wider than the address so
    // that a full-memory image (N == 2**ADDR_WIDTH) can be represented.
    localparam int          CW        = ADDR_WIDTH + 1;
    localparam logic [32:0] MAX_WORDS = 33'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_MAGIC = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_CSUM  = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [1:0]      r_byte_idx;
    logic [31:0]     r_shift;
    logic [CW-1:0]   r_len;
    logic [CW-1:0]   r_wcnt;
    logic [7:0]      r_csum;

    logic            r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [31:0]     r_wr_data;
    logic            r_done;
    logic            r_error;
    logic            r_core_rst_n;

    logic            w_in_ready;
    logic            w_accept;
    logic            w_last_byte;
    logic [31:0]     w_word;
    logic [CW-1:0]   w_wcnt_inc;
    logic            w_reload;
    logic            w_len_bad;
    logic            w_len_zero;
    logic            w_done_nxt;
    logic            w_error_nxt;

    // The incoming byte enters at the top of the shift register, so after
    // four bytes the first one received sits in bits [7:0] (little-endian).
    assign w_word      = {in_data, r_shift[31:8]};
    assign w_accept    = in_valid && in_ready;
    assign w_last_byte = (r_byte_idx == 2'd3);
    assign w_wcnt_inc  = r_wcnt + CW'(1);
    assign w_reload    = reload && ((r_state == S_DONE) || (r_state == S_ERR));
    assign w_len_bad   = ({1'b0, w_word} > MAX_WORDS);
    assign w_len_zero  = (w_word == 32'd0);

    // -----------------------------------------------------------------------
    // FSM process 1: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_MAGIC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM process 2: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_MAGIC: begin
                if (w_accept && w_last_byte) begin
                    w_state_nxt = (w_word == MAGIC) ? S_LEN : S_ERR;
                end
            end
            S_LEN: begin
                if (w_accept && w_last_byte) begin
                    if (w_len_bad) begin
                        w_state_nxt = S_ERR;
                    end else if (w_len_zero) begin
                        w_state_nxt = S_CSUM;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_accept && w_last_byte && (w_wcnt_inc == r_len)) begin
                    w_state_nxt = S_CSUM;
                end
            end
            S_CSUM: begin
                if (w_accept) begin
                    w_state_nxt = (in_data == r_csum) ? S_DONE : S_ERR;
                end
            end
            S_DONE, S_ERR: begin
                if (reload) begin
                    w_state_nxt = S_MAGIC;
                end
            end
            default: w_state_nxt = S_MAGIC;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM process 3: output decode
    // The status flags are decoded from the next state and then registered,
    // so done/error/core_rst_n change on the same edge as the state and are
    // free of decode glitches.
    // -----------------------------------------------------------------------
    always_comb begin
        w_in_ready  = 1'b0;
        w_done_nxt  = 1'b0;
        w_error_nxt = 1'b0;
        case (r_state)
            S_MAGIC, S_LEN, S_DATA, S_CSUM: w_in_ready = 1'b1;
            default:                        w_in_ready = 1'b0;
        endcase
        w_done_nxt  = (w_state_nxt == S_DONE);
        w_error_nxt = (w_state_nxt == S_ERR);
    end

    // Reset is synchronous, so the state may still read as active while rst
    // is low; gating with rst keeps the source from being handshaken then.
    assign in_ready = rst && w_in_ready;

    // -----------------------------------------------------------------------
    // Datapath: byte assembly, length capture, checksum, write port, flags
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_byte_idx   <= 2'd0;
            r_shift      <= 32'd0;
            r_len        <= '0;
            r_wcnt       <= '0;
            r_csum       <= 8'd0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= 32'd0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_core_rst_n <= 1'b0;
        end else begin
            // Write strobe is a single-cycle pulse; address/data hold.
            r_wr_en <= 1'b0;

            if (w_reload) begin
                r_byte_idx <= 2'd0;
                r_shift    <= 32'd0;
                r_len      <= '0;
                r_wcnt     <= '0;
                r_csum     <= 8'd0;
            end else if (w_accept) begin
                case (r_state)
                    S_MAGIC: begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        r_shift    <= w_word;
                    end
                    S_LEN: begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        r_shift    <= w_word;
                        if (w_last_byte && !w_len_bad) begin
                            r_len  <= w_word[CW-1:0];
                            r_wcnt <= '0;
                        end
                    end
                    S_DATA: begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        r_shift    <= w_word;
                        r_csum     <= r_csum ^ in_data;
                        if (w_last_byte) begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= r_wcnt[ADDR_WIDTH-1:0];
                            r_wr_data <= w_word;
                            r_wcnt    <= w_wcnt_inc;
                        end
                    end
                    default: begin
                        // CSUM byte is only compared; nothing to store.
                    end
                endcase
            end

            r_done       <= w_done_nxt;
            r_error      <= w_error_nxt;
            r_core_rst_n <= w_done_nxt;
        end
    end

    assign imem_wr_en   = r_wr_en;
    assign imem_wr_addr = r_wr_addr;
    assign imem_wr_data = r_wr_data;
    assign done         = r_done;
    assign error        = r_error;
    assign core_rst_n   = r_core_rst_n;

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
//
// Scoreboard bench for prog_loader. The stimulus side pushes every expected
// instruction-memory write (address, data, cycle it must appear in) into a
// queue as it sends the word's last byte; a monitor forked alongside pops
// and compares whenever imem_wr_en is seen. Status outputs are compared
// directly after each frame.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_prog_loader;

    localparam int          AW    = 10;
    localparam logic [31:0] MAGIC = 32'h4C564931;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data  = 8'd0;
    logic          reload   = 1'b0;
    logic          in_ready;
    logic          imem_wr_en;
    logic [AW-1:0] imem_wr_addr;
    logic [31:0]   imem_wr_data;
    logic          core_rst_n;
    logic          done;
    logic          error;

    prog_loader #(.ADDR_WIDTH(AW), .MAGIC(MAGIC)) dut (
        .clk          (clk),
        .rst          (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .reload       (reload),
        .imem_wr_en   (imem_wr_en),
        .imem_wr_addr (imem_wr_addr),
        .imem_wr_data (imem_wr_data),
        .core_rst_n   (core_rst_n),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          at;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] pay[$];
    int          gapmax    = 0;
    int          n_checks  = 0;
    int          n_errors  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents one byte and returns 1 time unit after the edge accepting it.
    task automatic send_byte(input logic [7:0] b);
        int t;
        if (gapmax > 0) idle(int'($urandom_range(0, gapmax)));
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 64) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!in_ready) begin
            check("send_ready_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    // Payload word: its write must appear in the cycle right after the edge
    // that accepted its last byte.
    task automatic send_pay_word(input int idx, input logic [31:0] w);
        wr_t e;
        send_word(w);
        e.addr = idx;
        e.data = w;
        e.at   = cyc;
        exp_q.push_back(e);
    endtask

    task automatic send_frame(input logic [31:0] n, input logic [7:0] csum);
        send_word(MAGIC);
        send_word(n);
        for (int i = 0; i < pay.size(); i++) send_pay_word(i, pay[i]);
        send_byte(csum);
        in_valid = 1'b0;
    endtask

    function automatic logic [7:0] csum_of();
        logic [7:0] c;
        c = 8'd0;
        foreach (pay[i]) c = c ^ pay[i][7:0] ^ pay[i][15:8] ^ pay[i][23:16] ^ pay[i][31:24];
        return c;
    endfunction

    task automatic pulse_reload();
        in_valid = 1'b0;
        reload   = 1'b1;
        @(posedge clk);
        #1;
        reload   = 1'b0;
    endtask

    task automatic monitor();
        logic prev;
        wr_t  e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (imem_wr_en) begin
                check("wr_strobe_single_cycle", 64'(prev), 64'd0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected no write (t=%0t)",
                             imem_wr_addr, imem_wr_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(imem_wr_addr), 64'(e.addr));
                    check("wr_data", 64'(imem_wr_data), 64'(e.data));
                    check("wr_cycle", 64'(cyc), 64'(e.at));
                end
            end
            prev = imem_wr_en;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            monitor();
        join_none

        // Reset state
        rst_n = 1'b0;
        idle(3);
        check("rst_in_ready",   64'(in_ready),     64'd0);
        check("rst_wr_en",      64'(imem_wr_en),   64'd0);
        check("rst_wr_addr",    64'(imem_wr_addr), 64'd0);
        check("rst_wr_data",    64'(imem_wr_data), 64'd0);
        check("rst_done",       64'(done),         64'd0);
        check("rst_error",      64'(error),        64'd0);
        check("rst_core_rst_n", 64'(core_rst_n),   64'd0);
        rst_n = 1'b1;
        idle(1);
        check("idle_in_ready",  64'(in_ready),     64'd1);

        // Good 2-word image; payload XOR is 0x2A
        pay = '{32'hDEADBEEF, 32'h12345678};
        send_frame(32'd2, 8'h2A);
        idle(2);
        check("good_done",       64'(done),       64'd1);
        check("good_core_rst_n", 64'(core_rst_n), 64'd1);
        check("good_error",      64'(error),      64'd0);
        check("good_in_ready",   64'(in_ready),   64'd0);
        check("good_pending",    64'(exp_q.size()), 64'd0);

        // reload together with in_valid in DONE: reload wins, byte dropped
        in_valid = 1'b1;
        in_data  = 8'h31;
        reload   = 1'b1;
        @(posedge clk);
        #1;
        reload   = 1'b0;
        in_valid = 1'b0;
        check("reload_done_cleared", 64'(done),       64'd0);
        check("reload_core_rst_n",   64'(core_rst_n), 64'd0);
        check("reload_in_ready",     64'(in_ready),   64'd1);

        // Bad magic: bytes 00 49 56 4C
        send_word(32'h4C564900);
        in_valid = 1'b0;
        check("badmagic_error",      64'(error),      64'd1);
        check("badmagic_in_ready",   64'(in_ready),   64'd0);
        check("badmagic_core_rst_n", 64'(core_rst_n), 64'd0);
        check("badmagic_done",       64'(done),       64'd0);
        idle(4);
        check("badmagic_sticky",     64'(error),      64'd1);

        // reload from ERR
        pulse_reload();
        check("reload_err_error",    64'(error),    64'd0);
        check("reload_err_in_ready", 64'(in_ready), 64'd1);

        // 1-word image with wrong checksum (correct value is 0x44)
        pay = '{32'h11223344};
        send_frame(32'd1, 8'h00);
        check("csum_bad_error",      64'(error),      64'd1);
        check("csum_bad_core_rst_n", 64'(core_rst_n), 64'd0);
        check("csum_bad_done",       64'(done),       64'd0);
        check("csum_bad_pending",    64'(exp_q.size()), 64'd0);
        pulse_reload();

        // N = 0, checksum 00: done, no writes
        pay.delete();
        send_frame(32'd0, 8'h00);
        idle(2);
        check("n0_done",  64'(done),  64'd1);
        check("n0_error", 64'(error), 64'd0);
        pulse_reload();

        // N = 2**AW + 1: error straight after the length field
        send_word(MAGIC);
        send_word(32'd1025);
        in_valid = 1'b0;
        check("nbig_error",    64'(error),    64'd1);
        check("nbig_in_ready", 64'(in_ready), 64'd0);
        pulse_reload();

        // Throttled 4-word image; payload XOR is 0x80
        gapmax = 3;
        pay = '{32'h03020100, 32'hA5A5A5A5, 32'hFFFFFFFF, 32'h00000080};
        send_frame(32'd4, 8'h80);
        gapmax = 0;
        idle(2);
        check("throttle_done",    64'(done),  64'd1);
        check("throttle_error",   64'(error), 64'd0);
        check("throttle_pending", 64'(exp_q.size()), 64'd0);
        pulse_reload();

        // rst mid-DATA after 2 bytes of word 1, then a full good image
        send_word(MAGIC);
        send_word(32'd2);
        send_pay_word(0, 32'hAABBCCDD);
        send_byte(8'h01);
        send_byte(8'h02);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        idle(1);
        check("midrst_in_ready", 64'(in_ready),   64'd0);
        check("midrst_wr_addr",  64'(imem_wr_addr), 64'd0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        pay = '{32'hDEADBEEF, 32'h12345678};
        send_frame(32'd2, 8'h2A);
        idle(2);
        check("midrst_done", 64'(done), 64'd1);
        pulse_reload();

        // Full-capacity image: N = 2**AW, last write at address 2**AW-1
        pay.delete();
        for (int i = 0; i < (1 << AW); i++) pay.push_back((i * 32'h9E3779B1) ^ 32'h5A5A0000);
        send_frame(32'd1024, csum_of());
        idle(2);
        check("full_done",  64'(done),  64'd1);
        check("full_error", 64'(error), 64'd0);

        idle(3);
        check("final_pending", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
